// File: rtl/cross_tx_sender_if.sv
// Producer write port and toggle-handshake transmit port of cross_tx_sender.
// master = the sender itself, slave = producer/receiver side.
interface cross_tx_sender_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (
        input  wr_data, wr_valid, tx_ready,
        output wr_ready, tx_data, tx_valid
    );

    modport slave (
        output wr_data, wr_valid, tx_ready,
        input  wr_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/cross_tx_sender.sv
// Transmit front end: FIFO-buffered producer words sent one at a time over a toggle handshake.
// Define CROSS_TX_TIMEOUT_EN to add the acknowledge watchdog, sticky timeout flag and ERROR state.
module cross_tx_sender #(
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_DEPTH_LOG2 = 3,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    cross_tx_sender_if.master        bus,
    output logic [FIFO_DEPTH_LOG2:0] level_o,
    output logic                     busy_o,
    output logic [31:0]              sent_count_o,
    output logic                     timeout_o,
    input  logic                     err_clear_i
);
    localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;

    typedef logic [FIFO_DEPTH_LOG2-1:0] ptr_t;
    typedef logic [FIFO_DEPTH_LOG2:0]   lvl_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK
`ifdef CROSS_TX_TIMEOUT_EN
        , ERROR
`endif
    } state_e;

    state_e                state_q, state_d;
    ptr_t                  wr_ptr_q, wr_ptr_d;
    ptr_t                  rd_ptr_q, rd_ptr_d;
    lvl_t                  level_q, level_d;
    logic [31:0]           sent_q, sent_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  not_full;
    logic                  tx_valid;
    logic                  wr_en;
    logic                  pop;

`ifdef CROSS_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    // A write is refused whenever the FIFO is full, even if a pop happens in the same cycle.
    assign not_full = (level_q != lvl_t'(DEPTH));
    assign wr_en    = bus.wr_valid & not_full;
    assign pop      = tx_valid & bus.tx_ready;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        tx_valid = 1'b0;
`ifdef CROSS_TX_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q & ~err_clear_i;
`endif
        unique case (state_q)
            IDLE: begin
                // tx_ready=1 here means any transfer left over in the receiver has finished.
                if (level_q != '0 && bus.tx_ready) state_d = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                if (bus.tx_ready) begin
                    state_d = WAIT_ACK;
`ifdef CROSS_TX_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            WAIT_ACK: begin
                if (bus.tx_ready) begin
                    state_d = IDLE;
                end
`ifdef CROSS_TX_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = ERROR;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
`ifdef CROSS_TX_TIMEOUT_EN
            ERROR: begin
                if (err_clear_i) begin
                    state_d = WAIT_ACK;
                    cnt_d   = '0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + ptr_t'(wr_en);
        rd_ptr_d = rd_ptr_q + ptr_t'(pop);
        level_d  = level_q + lvl_t'(wr_en) - lvl_t'(pop);
        sent_d   = sent_q + 32'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sent_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            sent_q   <= sent_d;
        end
    end

    // NOTE: FIFO storage is not reset; a slot is only visible on tx_data while level_q != 0.
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= bus.wr_data;
    end

`ifdef CROSS_TX_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_cfg;
    assign unused_cfg = err_clear_i ^ (TIMEOUT_CYCLES < 2);
    assign timeout_o  = 1'b0;
`endif

    assign bus.wr_ready = not_full;
    assign bus.tx_valid = tx_valid;
    assign bus.tx_data  = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign level_o      = level_q;
    assign busy_o       = (state_q != IDLE) || (level_q != '0);
    assign sent_count_o = sent_q;
endmodule

// File: tb/tb_cross_tx_sender.sv
// Self-checking bench for cross_tx_sender: scoreboard of written words, a toggle-style receiver
// model, and directed steps for latency, full FIFO, reset mid-transfer and the watchdog.
module tb_cross_tx_sender;
    localparam int DW    = 32;
    localparam int LOG2  = 3;
    localparam int DEPTH = 8;
    localparam int TO    = 64;
    localparam int GUARD = 400;

    logic          clk = 1'b0;
    logic          rst;
    logic          err_clear;
    logic [LOG2:0] level;
    logic          busy;
    logic          timeout;
    logic [31:0]   sent_count;

    cross_tx_sender_if #(.DATA_WIDTH(DW)) bus ();

    cross_tx_sender #(
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH_LOG2(LOG2),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock       (clk),
        .reset       (rst),
        .bus         (bus.master),
        .level_o     (level),
        .busy_o      (busy),
        .sent_count_o(sent_count),
        .timeout_o   (timeout),
        .err_clear_i (err_clear)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q [$];
    int            wr_since_reset = 0;
    int            sent_base = 0;
    int            rx_rd = 0;

    // Receiver: accepts while ready, drops ready the cycle after acceptance, raises it again
    // after a random delay unless rx_hold keeps it low.
    logic [DW-1:0] rx_log [1024];
    int            rx_count = 0;
    bit            rx_ready = 1'b1;
    bit            rx_pend = 1'b0;
    bit            rx_hold = 1'b0;
    int            rx_low = 0;

    assign bus.tx_ready = rx_ready;

    always @(negedge clk) begin
        if (bus.tx_valid === 1'b1 && rx_ready) begin
            rx_log[rx_count] = bus.tx_data;
            rx_count++;
            rx_pend = 1'b1;
        end else if (rx_pend) begin
            rx_ready = 1'b0;
            rx_pend  = 1'b0;
            rx_low   = int'($urandom_range(3, 0));
        end else if (!rx_ready) begin
            if (rx_low > 0) rx_low--;
            else if (!rx_hold) rx_ready = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_level();
        return wr_since_reset - (rx_count - sent_base);
    endfunction

    task automatic put_word(input logic [DW-1:0] d);
        int g = 0;
        bus.wr_data  = d;
        bus.wr_valid = 1'b1;
        while (bus.wr_ready !== 1'b1 && g < GUARD) begin
            tick();
            g++;
        end
        check("wr_accept_wait", 64'(g < GUARD), 64'd1);
        tick();
        bus.wr_valid = 1'b0;
        exp_q.push_back(d);
        wr_since_reset++;
    endtask

    task automatic wait_rx(input int target);
        int g = 0;
        while (rx_count < target && g < GUARD) begin
            tick();
            g++;
        end
        check("rx_wait", 64'(g < GUARD), 64'd1);
    endtask

    task automatic drain();
        int g = 0;
        while ((busy !== 1'b0 || !rx_ready || rx_pend) && g < GUARD) begin
            tick();
            g++;
        end
        check("drain_done", 64'(g < GUARD), 64'd1);
    endtask

    task automatic check_rx();
        while (rx_rd < rx_count) begin
            if (exp_q.size() > 0) check("rx_word", 64'(rx_log[rx_rd]), 64'(exp_q.pop_front()));
            else check("rx_extra_word", 64'(rx_rd), 64'(rx_count));
            rx_rd++;
        end
    endtask

    initial begin
        logic [DW-1:0] w;
        int            base;
        int            g;
        int            k;

        rst          = 1'b1;
        err_clear    = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        repeat (3) tick();
        check("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
        check("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        check("rst_tx_data", 64'(bus.tx_data), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sent", 64'(sent_count), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        rst = 1'b0;
        tick();

        // Single word: tx_valid rises in the second cycle after the write.
        put_word(32'hA5A5_0001);
        check("lat_valid_c1", 64'(bus.tx_valid), 64'd0);
        check("lat_data_c1", 64'(bus.tx_data), 64'hA5A5_0001);
        check("lat_busy_c1", 64'(busy), 64'd1);
        check("lat_level_c1", 64'(level), 64'd1);
        tick();
        check("lat_valid_c2", 64'(bus.tx_valid), 64'd1);
        check("lat_data_c2", 64'(bus.tx_data), 64'hA5A5_0001);
        drain();
        check_rx();
        check("one_sent", 64'(sent_count), 64'd1);
        check("one_level", 64'(level), 64'd0);
        check("one_busy", 64'(busy), 64'd0);

        // Fill: one word goes out and the receiver stalls, then words 1..8 fill the FIFO.
        rx_hold = 1'b1;
        base = rx_count;
        put_word(32'h0000_0100);
        wait_rx(base + 1);
        for (int i = 1; i <= DEPTH; i++) put_word(DW'(i));
        check("full_wr_ready", 64'(bus.wr_ready), 64'd0);
        check("full_level", 64'(level), 64'(model_level()));
        check("full_level_8", 64'(level), 64'd8);
        check("full_tx_valid", 64'(bus.tx_valid), 64'd0);

        // Keep writing while full; the pop cycle must not accept the pending word.
        bus.wr_data  = 32'd9;
        bus.wr_valid = 1'b1;
        rx_hold      = 1'b0;
        g = 0;
        while (level == 4'd8 && g < GUARD) begin
            tick();
            g++;
        end
        check("pop_level_7", 64'(level), 64'd7);
        tick();
        check("refill_level_8", 64'(level), 64'd8);
        bus.wr_valid = 1'b0;
        exp_q.push_back(32'd9);
        wr_since_reset++;
        drain();
        check_rx();
        check("fill_sent", 64'(sent_count), 64'(rx_count - sent_base));

        // Random traffic with random gaps and receiver latency.
        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            repeat ($urandom_range(2, 0)) tick();
            put_word(w);
            check("rand_level", 64'(level), 64'(model_level()));
            check_rx();
        end
        drain();
        check_rx();
        check("rand_sent", 64'(sent_count), 64'(rx_count - sent_base));
        check("rand_level_end", 64'(level), 64'd0);

        // Reset while waiting for the acknowledge with three words queued.
        rx_hold = 1'b1;
        base = rx_count;
        put_word(32'hC0DE_0001);
        put_word(32'hC0DE_0002);
        put_word(32'hC0DE_0003);
        put_word(32'hC0DE_0004);
        wait_rx(base + 1);
        tick();
        check("mid_level", 64'(level), 64'(model_level()));
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_rx();
        exp_q.delete();
        wr_since_reset = 0;
        sent_base = rx_count;
        check("mrst_level", 64'(level), 64'd0);
        check("mrst_tx_valid", 64'(bus.tx_valid), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_sent", 64'(sent_count), 64'd0);
        check("mrst_wr_ready", 64'(bus.wr_ready), 64'd1);
        put_word(32'h5EED_0001);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mrst_wait_ready", 64'(bus.tx_valid), 64'd0);
        end
        rx_hold = 1'b0;
        drain();
        check_rx();
        check("mrst_sent_after", 64'(sent_count), 64'd1);

        // Acknowledge never returns.
        rx_hold = 1'b1;
        base = rx_count;
        put_word(32'hBEEF_0001);
        wait_rx(base + 1);
        check("ack_entry_timeout", 64'(timeout), 64'd0);
`ifdef CROSS_TX_TIMEOUT_EN
        k = 0;
        while (timeout !== 1'b1 && k < 3 * TO) begin
            tick();
            k++;
        end
        check("to_cycles", 64'(k), 64'(TO));
        check("to_tx_valid", 64'(bus.tx_valid), 64'd0);
        put_word(32'hBEEF_0002);
        check("err_level", 64'(level), 64'(model_level()));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("err_no_send", 64'(bus.tx_valid), 64'd0);
        end
        rx_hold   = 1'b0;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("to_cleared", 64'(timeout), 64'd0);
`else
        k = 0;
        repeat (2 * TO) begin
            tick();
            k++;
        end
        check("no_to_flag", 64'(timeout), 64'd0);
        check("no_to_busy", 64'(busy), 64'd1);
        check("no_to_tx_valid", 64'(bus.tx_valid), 64'd0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("no_to_clear", 64'(timeout), 64'd0);
        rx_hold = 1'b0;
        put_word(32'hBEEF_0002);
`endif
        drain();
        check_rx();
        check("to_sent", 64'(sent_count), 64'(rx_count - sent_base));
        check("to_level", 64'(level), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
